lsu_arbiter: RTL and testbench

//  Sequences the single LSU memory pipeline among three requesters: committed store retirement
//  (store queue), load replay (load queue), and newly address-generated ops (issue/AGU stage).

---
 rtl/lsu_arbiter.sv | 144 ++++++++++++++
 tb/tb_lsu_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// LSU pipeline entry arbiter: picks one of store retire, load replay or new op per cycle
// into a single registered slot, with stall back-pressure, flush and new-op anti-starvation.
package lsu_arbiter_pkg;
  typedef enum logic [3:0] {
    LSU_FUNC_LB  = 4'd0,
    LSU_FUNC_LH  = 4'd1,
    LSU_FUNC_LW  = 4'd2,
    LSU_FUNC_LBU = 4'd3,
    LSU_FUNC_LHU = 4'd4,
    LSU_FUNC_SB  = 4'd5,
    LSU_FUNC_SH  = 4'd6,
    LSU_FUNC_SW  = 4'd7
  } lsu_func_t;
endpackage

module lsu_arbiter
  import lsu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_stall,
  input  logic                  i_sq_valid,
  input  logic [ADDR_WIDTH-1:0] i_sq_addr,
  input  logic [DATA_WIDTH-1:0] i_sq_data,
  input  logic [TAG_WIDTH-1:0]  i_sq_tag,
  input  lsu_func_t             i_sq_func,
  output logic                  o_sq_ready,
  input  logic                  i_lq_valid,
  input  logic [ADDR_WIDTH-1:0] i_lq_addr,
  input  logic [TAG_WIDTH-1:0]  i_lq_tag,
  input  lsu_func_t             i_lq_func,
  output logic                  o_lq_ready,
  input  logic                  i_new_valid,
  input  logic [ADDR_WIDTH-1:0] i_new_addr,
  input  logic [DATA_WIDTH-1:0] i_new_data,
  input  logic [TAG_WIDTH-1:0]  i_new_tag,
  input  lsu_func_t             i_new_func,
  output logic                  o_new_ready,
  output logic                  o_valid,
  output logic [1:0]            o_src,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output lsu_func_t             o_lsu_func
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] SRC_NEW    = 2'd0;
  localparam logic [1:0] SRC_REPLAY = 2'd1;
  localparam logic [1:0] SRC_RETIRE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [1:0]            src;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    lsu_func_t             func;
  } lsu_op_t;

  lsu_op_t          slot, gnt_op;
  logic             slot_vld;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved, kill, slot_open;
  logic             sq_gnt, lq_gnt, new_gnt, any_gnt;

  // A flush kills a speculative slot op, which frees the slot even under stall.
  // Committed retires are never killed, so they keep honouring the stall.
  assign kill      = i_flush && slot_vld && (slot.src != SRC_RETIRE);
  assign slot_open = !rst && (!slot_vld || !i_stall || kill);
  assign starved   = (starve_cnt == CNT_MAX);

  always_comb begin
    sq_gnt  = 1'b0;
    lq_gnt  = 1'b0;
    new_gnt = 1'b0;
    if (slot_open) begin
      if (i_flush)
        sq_gnt = i_sq_valid;
      else if (starved && i_new_valid)
        new_gnt = 1'b1;
      else if (i_sq_valid)
        sq_gnt = 1'b1;
      else if (i_lq_valid)
        lq_gnt = 1'b1;
      else
        new_gnt = i_new_valid;
    end
  end

  assign any_gnt     = sq_gnt || lq_gnt || new_gnt;
  assign o_sq_ready  = sq_gnt;
  assign o_lq_ready  = lq_gnt;
  assign o_new_ready = new_gnt;

  always_comb begin
    gnt_op = '{src: SRC_NEW, addr: '0, data: '0, tag: '0, func: LSU_FUNC_LB};
    if (sq_gnt)
      gnt_op = '{src: SRC_RETIRE, addr: i_sq_addr, data: i_sq_data,
                 tag: i_sq_tag, func: i_sq_func};
    else if (lq_gnt)
      gnt_op = '{src: SRC_REPLAY, addr: i_lq_addr, data: '0,
                 tag: i_lq_tag, func: i_lq_func};
    else if (new_gnt)
      gnt_op = '{src: SRC_NEW, addr: i_new_addr, data: i_new_data,
                 tag: i_new_tag, func: i_new_func};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld <= 1'b0;
      slot     <= '{src: SRC_NEW, addr: '0, data: '0, tag: '0, func: LSU_FUNC_LB};
    end else if (any_gnt) begin
      slot_vld <= 1'b1;
      slot     <= gnt_op;
    end else if (slot_open) begin
      slot_vld <= 1'b0;
    end
  end

  // Counts cycles a waiting new op loses an open slot; frozen while the slot is closed.
  always_ff @(posedge clk) begin
    if (rst || i_flush)
      starve_cnt <= '0;
    else if (slot_open) begin
      if (!i_new_valid || new_gnt)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign o_valid    = slot_vld;
  assign o_src      = slot.src;
  assign o_addr     = slot.addr;
  assign o_data     = slot.data;
  assign o_tag      = slot.tag;
  assign o_lsu_func = slot.func;
endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed checks of lsu_arbiter priority/stall/flush/starvation plus a random run
// against a small reference model of the slot.
module tb_lsu_arbiter;
  import lsu_arbiter_pkg::*;
  localparam int DW = 32, AW = 32, TW = 6, SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, i_flush, i_stall;
  logic i_sq_valid, i_lq_valid, i_new_valid;
  logic [AW-1:0] i_sq_addr, i_lq_addr, i_new_addr, o_addr;
  logic [DW-1:0] i_sq_data, i_new_data, o_data;
  logic [TW-1:0] i_sq_tag, i_lq_tag, i_new_tag, o_tag;
  lsu_func_t i_sq_func, i_lq_func, i_new_func, o_lsu_func;
  logic o_sq_ready, o_lq_ready, o_new_ready, o_valid;
  logic [1:0] o_src;

  lsu_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_stall(i_stall),
    .i_sq_valid(i_sq_valid), .i_sq_addr(i_sq_addr), .i_sq_data(i_sq_data),
    .i_sq_tag(i_sq_tag), .i_sq_func(i_sq_func), .o_sq_ready(o_sq_ready),
    .i_lq_valid(i_lq_valid), .i_lq_addr(i_lq_addr), .i_lq_tag(i_lq_tag),
    .i_lq_func(i_lq_func), .o_lq_ready(o_lq_ready),
    .i_new_valid(i_new_valid), .i_new_addr(i_new_addr), .i_new_data(i_new_data),
    .i_new_tag(i_new_tag), .i_new_func(i_new_func), .o_new_ready(o_new_ready),
    .o_valid(o_valid), .o_src(o_src), .o_addr(o_addr), .o_data(o_data),
    .o_tag(o_tag), .o_lsu_func(o_lsu_func)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_flush = 0; i_stall = 0;
    i_sq_valid = 0; i_lq_valid = 0; i_new_valid = 0;
    i_sq_addr = '0; i_lq_addr = '0; i_new_addr = '0;
    i_sq_data = '0; i_new_data = '0;
    i_sq_tag = '0; i_lq_tag = '0; i_new_tag = '0;
    i_sq_func = LSU_FUNC_SW; i_lq_func = LSU_FUNC_LW; i_new_func = LSU_FUNC_LW;
  endtask

  task automatic chk_rdy(input string tag, input logic sq, input logic lq, input logic nw);
    chk({tag, "_sq_rdy"}, 64'(o_sq_ready), 64'(sq));
    chk({tag, "_lq_rdy"}, 64'(o_lq_ready), 64'(lq));
    chk({tag, "_new_rdy"}, 64'(o_new_ready), 64'(nw));
  endtask

  // reference model of the slot
  logic          m_valid;
  logic [1:0]    m_src;
  logic [TW-1:0] m_tag;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [3:0]    m_func;
  int            m_cnt;
  int            sent, done;

  initial begin
    logic [5:0] exp_new;
    idle();
    rst = 1;
    i_sq_valid = 1; i_new_valid = 1;
    // 1: reset
    repeat (3) tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_src", 64'(o_src), 64'd0);
    chk("rst_tag", 64'(o_tag), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_func", 64'(o_lsu_func), 64'(LSU_FUNC_LB));
    chk_rdy("rst", 0, 0, 0);
    idle();
    rst = 0;
    tick(); tick();
    chk("idle_valid", 64'(o_valid), 64'd0);

    // 2: all three request, retire wins
    i_sq_valid = 1; i_sq_tag = 1; i_sq_addr = 32'h100; i_sq_data = 32'hAA;
    i_lq_valid = 1; i_lq_tag = 2;
    i_new_valid = 1; i_new_tag = 3;
    #1;
    chk_rdy("prio", 1, 0, 0);
    tick();
    chk("prio_valid", 64'(o_valid), 64'd1);
    chk("prio_src", 64'(o_src), 64'd2);
    chk("prio_tag", 64'(o_tag), 64'd1);
    chk("prio_data", 64'(o_data), 64'hAA);
    idle();
    tick();
    chk("drain_valid", 64'(o_valid), 64'd0);

    // 3: starvation, new wins on the 5th grant
    exp_new = 6'b010000;
    for (int k = 0; k < 6; k++) begin
      i_sq_valid = 1; i_sq_tag = TW'(10 + k);
      i_new_valid = 1; i_new_tag = 6'd40;
      #1;
      chk($sformatf("starve%0d_new_rdy", k), 64'(o_new_ready), 64'(exp_new[k]));
      chk($sformatf("starve%0d_sq_rdy", k), 64'(o_sq_ready), 64'(!exp_new[k]));
      tick();
      chk($sformatf("starve%0d_tag", k), 64'(o_tag), exp_new[k] ? 64'd40 : 64'(10 + k));
    end
    idle();
    tick();

    // 4: stall holds a new op; unknown func passes through
    i_new_valid = 1; i_new_tag = 5; i_new_data = 32'h55; i_new_addr = 32'h200;
    i_new_func = lsu_func_t'(4'hF);
    #1;
    chk_rdy("new", 0, 0, 1);
    tick();
    chk("new_src", 64'(o_src), 64'd0);
    chk("new_func", 64'(o_lsu_func), 64'hF);
    idle();
    i_stall = 1; i_lq_valid = 1; i_lq_tag = 7; i_lq_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_rdy($sformatf("stall%0d", k), 0, 0, 0);
      tick();
      chk($sformatf("stall%0d_valid", k), 64'(o_valid), 64'd1);
      chk($sformatf("stall%0d_tag", k), 64'(o_tag), 64'd5);
      chk($sformatf("stall%0d_data", k), 64'(o_data), 64'h55);
    end
    i_stall = 0;
    #1;
    chk_rdy("unstall", 0, 1, 0);
    tick();
    chk("replay_src", 64'(o_src), 64'd1);
    chk("replay_data", 64'(o_data), 64'd0);
    chk("replay_tag", 64'(o_tag), 64'd7);

    // 5: flush under stall kills replay, retire enters; then retire held
    i_stall = 1; i_flush = 1;
    i_sq_valid = 1; i_sq_tag = 9; i_lq_valid = 1; i_lq_tag = 11;
    i_new_valid = 1; i_new_tag = 12;
    #1;
    chk_rdy("flush", 1, 0, 0);
    tick();
    chk("flush_valid", 64'(o_valid), 64'd1);
    chk("flush_src", 64'(o_src), 64'd2);
    chk("flush_tag", 64'(o_tag), 64'd9);
    i_sq_tag = 13;
    #1;
    chk_rdy("flush_hold", 0, 0, 0);
    tick();
    chk("hold_valid", 64'(o_valid), 64'd1);
    chk("hold_tag", 64'(o_tag), 64'd9);
    idle();
    tick();
    chk("after_valid", 64'(o_valid), 64'd0);

    // 6: random traffic against the model
    rst = 1; tick(); rst = 0;
    m_valid = 0; m_src = 0; m_tag = '0; m_addr = '0; m_data = '0; m_func = 4'd0; m_cnt = 0;
    sent = 0; done = 0;
    for (int c = 0; c < 4000; c++) begin
      int w;
      logic open;
      chk("rnd_valid", 64'(o_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rnd_src", 64'(o_src), 64'(m_src));
        chk("rnd_tag", 64'(o_tag), 64'(m_tag));
        chk("rnd_addr", 64'(o_addr), 64'(m_addr));
        chk("rnd_data", 64'(o_data), 64'(m_data));
        chk("rnd_func", 64'(o_lsu_func), 64'(m_func));
      end
      i_flush = ($urandom_range(0, 19) == 0);
      i_stall = ($urandom_range(0, 3) == 0);
      i_sq_valid = $urandom_range(0, 1) != 0;
      i_lq_valid = $urandom_range(0, 1) != 0;
      i_new_valid = $urandom_range(0, 2) != 0;
      i_sq_tag = TW'($urandom); i_lq_tag = TW'($urandom); i_new_tag = TW'($urandom);
      i_sq_addr = $urandom; i_lq_addr = $urandom; i_new_addr = $urandom;
      i_sq_data = $urandom; i_new_data = $urandom;
      i_sq_func = lsu_func_t'($urandom_range(0, 15));
      i_lq_func = lsu_func_t'($urandom_range(0, 15));
      i_new_func = lsu_func_t'($urandom_range(0, 15));
      #1;
      open = !m_valid || !i_stall || (i_flush && m_src != 2'd2);
      w = -1;
      if (open) begin
        if (i_flush) w = i_sq_valid ? 2 : -1;
        else if (m_cnt == SL && i_new_valid) w = 0;
        else if (i_sq_valid) w = 2;
        else if (i_lq_valid) w = 1;
        else if (i_new_valid) w = 0;
      end
      chk_rdy("rnd", w == 2, w == 1, w == 0);
      if (i_sq_valid && o_sq_ready) sent++;
      if (o_valid && o_src == 2'd2 && !i_stall) done++;
      if (w == 2) begin
        m_valid = 1; m_src = 2; m_tag = i_sq_tag; m_addr = i_sq_addr;
        m_data = i_sq_data; m_func = i_sq_func;
      end else if (w == 1) begin
        m_valid = 1; m_src = 1; m_tag = i_lq_tag; m_addr = i_lq_addr;
        m_data = '0; m_func = i_lq_func;
      end else if (w == 0) begin
        m_valid = 1; m_src = 0; m_tag = i_new_tag; m_addr = i_new_addr;
        m_data = i_new_data; m_func = i_new_func;
      end else if (open) begin
        m_valid = 0;
      end
      if (i_flush) m_cnt = 0;
      else if (open) m_cnt = (!i_new_valid || w == 0) ? 0 : (m_cnt < SL ? m_cnt + 1 : SL);
      tick();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      #1;
      if (o_valid && o_src == 2'd2) done++;
      tick();
    end
    chk("retire_once", 64'(done), 64'(sent));
    chk("drained", 64'(o_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
